// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

    // Transmit frame sequencer states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Number of bit periods in one frame: start + data + optional parity + stop.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, held at zero otherwise.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    // The tick marks the final cycle of the current bit period.
    assign bit_tick = en && (cnt_q == LAST);

    // Free-running bit-period counter, cleared whenever the transmitter is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en || bit_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: valid/ready word intake, framing, registered serial output.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | line high, ready for a word
// S_START  | driving the start bit (low)
// S_DATA   | shifting data bits out, LSB first
// S_PARITY | driving the parity bit (only when enabled)
// S_STOP   | driving 1 or 2 stop bits (high)
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    // The shift register holds the longest possible frame.
    localparam int SR_W       = DATA_BITS + 4;
    localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY, STOP_BITS);
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_core: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_core: DATA_BITS must be in 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_core: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_core: STOP_BITS must be 1 or 2");
    end
    if (FRAME_BITS > SR_W) begin : g_bad_frame
        $error("uart_tx_core: frame does not fit the shift register");
    end

    uart_state_t     state_q, state_d;
    logic [SR_W-1:0] shift_q, shift_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic            serial_q, serial_d;
    logic            done_q, done_d;
    logic            bit_tick;
    logic            accept;
    logic            par_bit;
    logic [SR_W-1:0] load_word;

    assign tx_ready  = (state_q == S_IDLE);
    assign tx_busy   = (state_q != S_IDLE);
    assign tx_serial = serial_q;
    assign tx_done   = done_q;
    assign accept    = tx_valid & tx_ready;
    assign par_bit   = (PARITY == PAR_ODD) ? ~(^tx_data) : (^tx_data);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (tx_busy),
        .bit_tick (bit_tick)
    );

    // Frame image loaded on accept; unused parity/stop positions stay 1.
    always_comb begin
        load_word                = '1;
        load_word[0]             = 1'b0;
        load_word[DATA_BITS:1]   = tx_data;
        if (PARITY != PAR_NONE) begin
            load_word[DATA_BITS+1] = par_bit;
        end
    end

    // Next-state, shift and bit-count logic; serial/done are precomputed for registering.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;

        if (bit_tick) begin
            shift_d = {1'b1, shift_q[SR_W-1:1]};
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_START;
                    shift_d   = load_word;
                    bit_cnt_d = '0;
                end
            end
            S_START: begin
                if (bit_tick) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_tick) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
            end
        endcase

        serial_d = (state_d == S_IDLE) ? 1'b1 : shift_d[0];
    end

    // State, shift register, bit counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '1;
            bit_cnt_q <= '0;
            serial_q  <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            serial_q  <= serial_d;
            done_q    <= done_d;
        end
    end

endmodule
